// File: rtl/ifmap_pkg.sv
// Shared types for the ifmap decompressor: output packet layout, token field
// positions and decoder state encoding.
package ifmap_pkg;

    localparam int TOK_W         = 16;
    localparam int TOK_RUN_BIT   = 15;
    localparam int TOK_VAL_W     = 8;
    localparam int TOKS_PER_WORD = 4;
    localparam int LANES         = 8;

    typedef struct packed {
        logic [63:0] data;
        logic [5:0]  row_idx;
        logic [4:0]  col_idx;
        logic        last;
    } DECOMRPESS_FIFO_PACKET;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_DRAIN,
        ST_DONE
    } dec_state_e;

endpackage

// File: rtl/ifmap_decompressor_if.sv
// Global-buffer read port plus the decompressed-packet port toward ifmap_buffer.
// master = decompressor side, slave = global buffer / ifmap_buffer side.
interface ifmap_decompressor_if;
    import ifmap_pkg::*;

    logic [63:0]           gb_rdata;
    logic                  gb_rvalid;
    logic                  gb_rready;
    logic                  global_buffer_req;
    DECOMRPESS_FIFO_PACKET decompressed_fifo_packet;
    logic                  decompressor_ack;

    modport master (
        input  gb_rdata, gb_rvalid, global_buffer_req,
        output gb_rready, decompressed_fifo_packet, decompressor_ack
    );

    modport slave (
        output gb_rdata, gb_rvalid, global_buffer_req,
        input  gb_rready, decompressed_fifo_packet, decompressor_ack
    );

endinterface

// File: rtl/ifmap_byte_packer.sv
// Collects decoded bytes into an 8-lane group and holds each finished group in
// the packet register until ifmap_buffer takes it.
module ifmap_byte_packer
    import ifmap_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [LANES-1:0]      wr_mask,
    input  logic [63:0]           wr_data,
    input  logic                  group_full,
    input  logic [5:0]            row_idx,
    input  logic [4:0]            col_idx,
    input  logic                  last,
    input  logic                  req,
    output DECOMRPESS_FIFO_PACKET pkt,
    output logic                  pkt_valid,
    output logic                  ack
);

    logic [63:0] lane_buf;
    logic [63:0] merged;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        merged = lane_buf;
        for (int k = 0; k < LANES; k++) begin
            if (wr_mask[k]) merged[8*k +: 8] = wr_data[8*k +: 8];
        end
    end

    assign ack = pkt_valid && req;

    // NOTE: the lane buffer is reset along with everything else so a partial group never leaks into a new map.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_buf  <= '0;
            pkt       <= '0;
            pkt_valid <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
            if (wr_en) begin
                if (group_full) begin
                    pkt.data    <= merged;
                    pkt.row_idx <= row_idx;
                    pkt.col_idx <= col_idx;
                    pkt.last    <= last;
                    lane_buf    <= '0;
                end else begin
                    lane_buf    <= merged;
                end
            end
            if (wr_en && group_full) pkt_valid <= 1'b1;
            else if (ack)            pkt_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ifmap_decompressor.sv
// Fetches compressed words, expands literal / zero-run tokens into rows and emits 8-byte packets.
// Optional build macro DECOMP_OVERRUN_CHECK_EN enables the sticky row-overrun err flag.
module ifmap_decompressor
    import ifmap_pkg::*;
#(
    parameter int ROWS      = 35,
    parameter int ROW_BYTES = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    ifmap_decompressor_if.master        bus,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int PTR_W  = $clog2(ROW_BYTES);
    localparam int GROUPS = ROW_BYTES / LANES;

    dec_state_e       state;
    logic [63:0]      word;
    logic [1:0]       tok_idx;
    logic [8:0]       run_rem;
    logic             run_active;
    logic [PTR_W-1:0] byte_ptr;
    logic [5:0]       row_idx;
    logic             rready_q;

    logic             tok_run;
    logic [7:0]       tok_val;
    logic [9:0]       lane, pos, avail, room, n, pos_next, left;
    logic             row_end, group_full, consume, is_lit, last_row, stall, step;
    logic [LANES-1:0] wr_mask;
    logic [63:0]      wr_data;
    logic [4:0]       col_idx;
    logic             col_last;
    logic             pkt_valid, ack;

    assign tok_run = word[{tok_idx, 4'd15}];
    assign tok_val = word[{tok_idx, 4'd0} +: TOK_VAL_W];

    // A pending run continues from run_rem; otherwise the current token defines the byte count.
    always_comb begin
        lane       = {7'd0, byte_ptr[2:0]};
        pos        = 10'(byte_ptr);
        is_lit     = !run_active && !tok_run;
        avail      = run_active ? {1'b0, run_rem} : (tok_run ? 10'(tok_val) + 10'd1 : 10'd1);
        room       = 10'd8 - lane;
        n          = (avail < room) ? avail : room;
        pos_next   = pos + n;
        row_end    = (pos_next == 10'(ROW_BYTES));
        left       = avail - n;
        group_full = ((lane + n) == 10'd8);
        consume    = row_end || (left == 10'd0);
        wr_data    = is_lit ? {LANES{tok_val}} : 64'd0;
        wr_mask    = '0;
        for (int k = 0; k < LANES; k++) begin
            wr_mask[k] = (10'(k) >= lane) && (10'(k) < lane + n);
        end
    end

    assign last_row = (row_idx == 6'(ROWS - 1));
    assign col_idx  = 5'(byte_ptr >> 3);
    assign col_last = (col_idx == 5'(GROUPS - 1));
    assign stall    = group_full && pkt_valid && !ack;
    assign step     = (state == ST_DECODE) && !stall;

    ifmap_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (step),
        .wr_mask    (wr_mask),
        .wr_data    (wr_data),
        .group_full (group_full),
        .row_idx    (row_idx),
        .col_idx    (col_idx),
        .last       (col_last),
        .req        (bus.global_buffer_req),
        .pkt        (bus.decompressed_fifo_packet),
        .pkt_valid  (pkt_valid),
        .ack        (ack)
    );

    assign bus.decompressor_ack = ack;
    assign bus.gb_rready        = rready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            word       <= '0;
            tok_idx    <= '0;
            run_rem    <= '0;
            run_active <= 1'b0;
            byte_ptr   <= '0;
            row_idx    <= '0;
            rready_q   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= ST_FETCH;
                        rready_q   <= 1'b1;
                        busy       <= 1'b1;
                        row_idx    <= '0;
                        byte_ptr   <= '0;
                        run_active <= 1'b0;
                        run_rem    <= '0;
                    end
                end
                ST_FETCH: begin
                    if (bus.gb_rvalid && rready_q) begin
                        word     <= bus.gb_rdata;
                        tok_idx  <= '0;
                        rready_q <= 1'b0;
                        state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!stall) begin
                        run_active <= !consume;
                        run_rem    <= left[8:0];
                        if (row_end) begin
                            byte_ptr <= '0;
                            if (!last_row) row_idx <= row_idx + 6'd1;
                        end else begin
                            byte_ptr <= pos_next[PTR_W-1:0];
                        end
                        // The final row's end abandons whatever tokens remain in the word.
                        if (row_end && last_row) begin
                            state <= ST_DRAIN;
                        end else if (consume) begin
                            tok_idx <= tok_idx + 2'd1;
                            if (tok_idx == 2'(TOKS_PER_WORD - 1)) begin
                                state    <= ST_FETCH;
                                rready_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (ack) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DECOMP_OVERRUN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              err <= 1'b0;
        else if (state == ST_IDLE && start)      err <= 1'b0;
        else if (step && row_end && left != '0)  err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule
